icache_line_fetch: RTL
======================

ICACHE_LINE_FETCH -- requirements
Module: icache_line_fetch

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 4, words per fetched line; legal values 2, 4, 8.
REQ-002 SHALL have parameter BUF_EN, default 1; 1 enables the one-line reuse buffer, 0 refetches on every request.
REQ-003 SHALL have port clk, in, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, in, 1, asynchronous active-high reset.
REQ-005 SHALL have port ireq_valid, in, 1, fetch request pending.
REQ-006 SHALL have port ireq_addr, in, 32, virtual fetch address.
REQ-007 SHALL have port flush, in, 1, abandon the current request and invalidate the buffer.
REQ-008 SHALL have port iresp_data_ok, out, 1, single-cycle pulse marking a valid line response.
REQ-009 SHALL have port iresp_data, out, 32*LINE_WORDS, the line; word i in bits [32i+31:32i].
REQ-010 SHALL have port iresp_predecode, out, 2*LINE_WORDS, per-word class; 0 normal, 1 branch, 2 ret, 3 call.
REQ-011 SHALL have ports creq_valid (out, 1), creq_addr (out, 32) and creq_len (out, 4, burst beats minus 1); cresp_ready, cresp_last (in, 1 each); cresp_data (in, 32).

Function
REQ-012 SHALL translate addresses: vaddr[31:28] 8 or A -> 0, 9 or B -> 1, otherwise unchanged; bits [27:0] pass through.
REQ-013 SHALL compute line address = paddr with its low log2(LINE_WORDS)+2 bits cleared.
REQ-014 SHALL use FSM states IDLE, REQ, REFILL, RESP.
REQ-015 In IDLE with ireq_valid: on a buffer hit (BUF_EN=1, buffer valid, tag equal to line address) SHALL go to RESP; otherwise SHALL go to REQ.
REQ-016 In REQ SHALL hold creq_valid=1, creq_addr=line address and creq_len=LINE_WORDS-1; read-only, size 4 bytes; SHALL go to REFILL on the first cycle that cresp_ready=1, capturing that beat.
REQ-017 In REFILL SHALL store cresp_data into word[beat] on each cycle with cresp_ready=1 and increment a log2(LINE_WORDS)-bit beat counter; creq_valid SHALL stay 1 until the beat with cresp_last=1.
REQ-018 On the beat with cresp_last=1 SHALL write the buffer tag, set the buffer valid, clear the beat counter and go to RESP; cresp_last SHALL end the burst regardless of the count.
REQ-019 In RESP SHALL assert iresp_data_ok for exactly one cycle with the buffer line and predecode, then return to IDLE.
REQ-020 Predecode SHALL be registered at line completion: branch = opcode 04..07, 02, or opcode 00 with funct 09, or opcode 01 with rt 00, 01, 10, 11; ret = opcode 00, rs 31, funct 08; call = opcode 03; else normal; branch has priority.
REQ-021 Refill-to-response latency SHALL be 1 cycle after the last beat; a buffer hit SHALL respond 1 cycle after acceptance in IDLE.
REQ-022 Flush in IDLE, REQ or RESP SHALL clear the buffer valid and go to IDLE with no data_ok; flush in REFILL SHALL keep creq_valid until cresp_last, then discard the line and go to IDLE.
REQ-023 ireq_addr SHALL be sampled only in IDLE; changes during a transaction SHALL be ignored.
REQ-024 With BUF_EN=0 a hit SHALL never occur.

Reset
REQ-025 Asserting reset SHALL immediately set the state to IDLE and all outputs to 0, clear the buffer valid and zero the beat counter, data and predecode; an in-flight burst SHALL be abandoned.
REQ-026 After reset deassertion the first ireq_valid SHALL always miss.

Verification
REQ-027 LINE_WORDS=4, ireq 0xBFC00004, miss; beats 0x10000001, 0x0C000010, 0x03E00008, 0x00000000 -> creq_addr 0x1FC00000, creq_len 3, data_ok 1 cycle after last, predecode {0,2,3,1}.
REQ-028 Repeat ireq 0xBFC0000C after REQ-027 -> no creq_valid, data_ok 1 cycle after acceptance, same line.
REQ-029 cresp_ready low 3 cycles between beats -> data correct, creq_valid held throughout, no early data_ok.
REQ-030 Flush on beat 2 -> burst completes, no data_ok, next request to the same line misses.
REQ-031 reset pulsed mid-REFILL -> outputs 0 within the same cycle, next request refetches.
REQ-032 LINE_WORDS=8, BUF_EN=0, ireq 0x80001234 twice -> two bursts, creq_addr 0x00001220, creq_len 7.

Source files
------------

// File: rtl/icache_line_fetch.sv
// icache_line_fetch: fetches instruction lines over a burst bus, keeps one line for reuse
// and registers a per-word branch/ret/call predecode alongside it.
module icache_line_fetch #(
  parameter int LINE_WORDS = 4,
  parameter bit BUF_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ireq_valid,
  input  logic [31:0]              ireq_addr,
  input  logic                     flush,
  output logic                     iresp_data_ok,
  output logic [32*LINE_WORDS-1:0] iresp_data,
  output logic [2*LINE_WORDS-1:0]  iresp_predecode,
  output logic                     creq_valid,
  output logic [31:0]              creq_addr,
  output logic [3:0]               creq_len,
  input  logic                     cresp_ready,
  input  logic                     cresp_last,
  input  logic [31:0]              cresp_data
);
  localparam int BW = $clog2(LINE_WORDS);
  localparam int OB = BW + 2;
  typedef enum logic [1:0] {IDLE, REQ, REFILL, RESP} state_t;
  state_t state;
  logic buf_valid;
  logic flushed;
  logic [BW-1:0] beat;
  logic [31:0] tag;
  logic [31:0] paddr;
  logic [31:0] line_addr;
  logic hit;
  logic [32*LINE_WORDS-1:0] line_next;
  logic [2*LINE_WORDS-1:0] pd_next;
  function automatic logic [1:0] classify(input logic [31:0] w);
    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic br;
    op = w[31:26];
    rs = w[25:21];
    rt = w[20:16];
    funct = w[5:0];
    br = (op inside {[6'h04:6'h07], 6'h02}) || (op == 6'h00 && funct == 6'h09) ||
         (op == 6'h01 && rt inside {5'h00, 5'h01, 5'h10, 5'h11});
    return br ? 2'd1 : (op == 6'h00 && rs == 5'd31 && funct == 6'h08) ? 2'd2 : (op == 6'h03) ? 2'd3 : 2'd0;
  endfunction
  // kseg0/kseg1 (0x8-0xB) fold onto the low 512 MB of physical space
  assign paddr = (ireq_addr[31:30] == 2'b10) ? {3'b000, ireq_addr[28:0]} : ireq_addr;
  assign line_addr = {paddr[31:OB], {OB{1'b0}}};
  assign hit = BUF_EN && buf_valid && (tag == line_addr);
  always_comb begin
    line_next = iresp_data;
    line_next[{beat, 5'b0} +: 32] = cresp_data;
    pd_next = '0;
    for (int i = 0; i < LINE_WORDS; i++) pd_next[2*i +: 2] = classify(line_next[32*i +: 32]);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      iresp_data_ok <= 1'b0;
      iresp_data <= '0;
      iresp_predecode <= '0;
      creq_valid <= 1'b0;
      creq_addr <= '0;
      creq_len <= '0;
      buf_valid <= 1'b0;
      flushed <= 1'b0;
      beat <= '0;
      tag <= '0;
    end else begin
      iresp_data_ok <= 1'b0;
      case (state)
        IDLE: begin
          if (flush) begin
            buf_valid <= 1'b0;
          end else if (ireq_valid && hit) begin
            state <= RESP;
            iresp_data_ok <= 1'b1;
          end else if (ireq_valid) begin
            // the refill overwrites the buffer in place, so it stops being a valid line now
            state <= REQ;
            buf_valid <= 1'b0;
            flushed <= 1'b0;
            creq_valid <= 1'b1;
            creq_addr <= line_addr;
            creq_len <= 4'(LINE_WORDS - 1);
          end
        end
        REQ, REFILL: begin
          if (flush && state == REQ) begin
            state <= IDLE;
            buf_valid <= 1'b0;
            creq_valid <= 1'b0;
            beat <= '0;
          end else begin
            if (flush) flushed <= 1'b1;
            if (cresp_ready) begin
              iresp_data <= line_next;
              beat <= beat + 1'b1;
              state <= REFILL;
              if (cresp_last) begin
                beat <= '0;
                creq_valid <= 1'b0;
                if (flushed || flush) begin
                  state <= IDLE;
                end else begin
                  state <= RESP;
                  iresp_data_ok <= 1'b1;
                  buf_valid <= 1'b1;
                  tag <= creq_addr;
                  iresp_predecode <= pd_next;
                end
              end
            end
          end
        end
        RESP: begin
          state <= IDLE;
          if (flush) buf_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
